// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and frame length helper.
// Used by both the transmitter and the oversampling receiver.
package uart_pkg;

  // Frame state encoding shared with the receiver (3-bit, PARITY reserved).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Line levels: mark (idle/stop) is high, start bit is low.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input int unsigned stop_bits,
                                             input bit          parity_en);
    return 1 + data_width + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/transmitter.sv
// UART serial transmitter. Sends start bit, DATA_WIDTH data bits LSB-first,
// an optional even-parity bit and STOP_BITS stop bits, with every bit lasting
// OVERSAMPLE_RATE pulses of the shared baud tick.
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit.
module transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int STOP_BITS       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_in,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TICK_W = $clog2(OVERSAMPLE_RATE);
  // Wide enough for DATA_WIDTH-1 (data index) and STOP_BITS-1 (stop index).
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE_RATE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_e           state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // The current bit period closes on the last tick of the oversample window.
  assign bit_end = tick && (tick_cnt == TICK_LAST);

  // Frame sequencer: counters, shift register and all registered outputs.
  // NOTE: every register here is assigned with <= so all state updates use
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_out    <= LINE_IDLE;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // NOTE: tx_done defaults low every cycle so it can only ever be a
      // single-clock pulse, set by the one branch below that ends a frame.
      tx_done <= 1'b0;

      // Ticks only advance the bit timer while a frame is in flight.
      if (state != IDLE && tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          tx_out <= LINE_IDLE;
          if (tx_start) begin
            shift_reg <= tx_in;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            tx_out    <= LINE_START;
            tx_busy   <= 1'b1;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_in;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx_out  <= shift_reg[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx_out <= parity_bit;
              state  <= PARITY;
`else
              tx_out <= LINE_IDLE;
              state  <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx_out  <= LINE_IDLE;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          // bit_cnt counts completed stop bits; the frame ends on the last tick.
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx_out  <= LINE_IDLE;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
